// File: rtl/rv32_decode_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {prediction, instr, pc} entries with flush.
// Optional same-cycle bypass of an empty queue when RV32_DECODE_QUEUE_BYPASS_EN is defined.
module rv32_decode_queue #(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic [INSTR_WIDTH-1:0]       instr_in,
  input  logic                         branch_predicted_taken_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic [INSTR_WIDTH-1:0]       instr_out,
  output logic                         branch_predicted_taken_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W   = ADDR_W + 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   occupancy;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               push_store;
  logic               pop_store;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] out_entry;

  // Pointer MSB distinguishes full from empty, so the difference is the occupancy.
  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == PTR_W'(DEPTH));
  assign count_out = CNT_W'(occupancy);
  assign ready_out = !full && !reset;

  assign entry_in   = {branch_predicted_taken_in, instr_in, pc_in};
  assign head_entry = mem[rd_ptr_reg[ADDR_W-1:0]];

`ifdef RV32_DECODE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = empty && valid_in && !flush_in && !reset;
`endif

  always_comb begin
    valid_out = !empty && !reset;
    out_entry = head_entry;
`ifdef RV32_DECODE_QUEUE_BYPASS_EN
    if (bypass) begin
      valid_out = 1'b1;
      out_entry = entry_in;
    end
`endif
    if (!valid_out) out_entry = '0;
  end

  assign {branch_predicted_taken_out, instr_out, pc_out} = out_entry;

  assign push = valid_in && ready_out && !flush_in;
  assign pop  = valid_out && ready_in;

`ifdef RV32_DECODE_QUEUE_BYPASS_EN
  // A bypassed entry taken by decode is never written into storage.
  assign push_store = push && !(bypass && ready_in);
  assign pop_store  = pop && !bypass;
`else
  assign push_store = push;
  assign pop_store  = pop;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_store) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_store)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) mem[wr_ptr_reg[ADDR_W-1:0]] <= entry_in;
  end

endmodule

// File: tb/tb_rv32_decode_queue.sv
// Directed table-driven bench for rv32_decode_queue (DEPTH=4) plus wrap and bypass sequences.
module tb_rv32_decode_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        branch_predicted_taken_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        branch_predicted_taken_out;
  logic [2:0]  count_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_decode_queue #(.DEPTH(4), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in), .valid_in(valid_in),
    .ready_out(ready_out), .pc_in(pc_in), .instr_in(instr_in),
    .branch_predicted_taken_in(branch_predicted_taken_in),
    .valid_out(valid_out), .ready_in(ready_in), .pc_out(pc_out),
    .instr_out(instr_out),
    .branch_predicted_taken_out(branch_predicted_taken_out),
    .count_out(count_out)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        vin;
    logic [31:0] pc;
    logic        rin;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic flush, input logic vin,
                       input logic [31:0] pc, input logic rin);
    reset = rst; flush_in = flush; valid_in = vin; ready_in = rin;
    pc_in = pc; instr_in = instr_of(pc); branch_predicted_taken_in = pc[2];
  endtask

  task automatic check_outputs(input string tag, input logic e_rdy, input logic e_vld,
                               input logic [31:0] e_pc, input logic [2:0] e_cnt);
    check({tag, " ready_out"}, 32'(ready_out), 32'(e_rdy));
    check({tag, " valid_out"}, 32'(valid_out), 32'(e_vld));
    check({tag, " pc_out"}, pc_out, e_pc);
    check({tag, " instr_out"}, instr_out, e_vld ? instr_of(e_pc) : 32'h0);
    check({tag, " bpt_out"}, 32'(branch_predicted_taken_out), e_vld ? 32'(e_pc[2]) : 32'h0);
    check({tag, " count_out"}, 32'(count_out), 32'(e_cnt));
  endtask

  function automatic vec_t mk(input logic rst, input logic flush, input logic vin,
                              input logic [31:0] pc, input logic rin, input logic er,
                              input logic ev, input logic [31:0] epc, input logic [2:0] ec);
    vec_t v;
    v.rst = rst; v.flush = flush; v.vin = vin; v.pc = pc; v.rin = rin;
    v.exp_ready = er; v.exp_valid = ev; v.exp_pc = epc; v.exp_count = ec;
    return v;
  endfunction

  logic [31:0] model_q[$];
  logic        m_valid;
  logic [31:0] m_pc;

  initial begin
    // Expectations are the outputs seen before the edge that applies the vector.
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,1,32'h100,0, 1,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,1,32'h104,0, 1,1,32'h100,3'd1));
    vecs.push_back(mk(0,0,1,32'h108,0, 1,1,32'h100,3'd2));
    vecs.push_back(mk(0,0,1,32'h10C,0, 1,1,32'h100,3'd3));
    vecs.push_back(mk(0,0,1,32'h110,0, 0,1,32'h100,3'd4));
    vecs.push_back(mk(0,0,1,32'h110,0, 0,1,32'h100,3'd4));
    vecs.push_back(mk(0,0,0,32'h0,  1, 0,1,32'h100,3'd4));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,1,32'h104,3'd3));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,1,32'h108,3'd2));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,1,32'h10C,3'd1));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,1,32'h120,0, 1,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,1,32'h124,0, 1,1,32'h120,3'd1));
    vecs.push_back(mk(0,0,1,32'h128,0, 1,1,32'h120,3'd2));
    vecs.push_back(mk(0,1,1,32'h200,1, 1,1,32'h120,3'd3));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,1,32'h130,0, 1,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,1,32'h134,0, 1,1,32'h130,3'd1));
    vecs.push_back(mk(1,0,1,32'h138,0, 0,0,32'h0,  3'd2));
    vecs.push_back(mk(1,0,1,32'h138,0, 0,0,32'h0,  3'd0));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,0,32'h0,  3'd0));

    drive(1, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_hold", 1'b0, 1'b0, 32'h0, 3'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].pc, vecs[i].rin);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                    vecs[i].exp_pc, vecs[i].exp_count);
      $display("vec%0d: rst=%0d flush=%0d vin=%0d pc_in=0x%0h rin=%0d -> valid=%0d pc_out=0x%0h count=%0d",
               i, vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].pc, vecs[i].rin,
               valid_out, pc_out, count_out);
    end

    // Streaming push and pop across pointer wrap, checked against a queue model.
    model_q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(0, 0, (c < 10), 32'h400 + 32'(c) * 4, 1);
      #1;
      m_valid = (model_q.size() != 0);
      m_pc    = m_valid ? model_q[0] : 32'h0;
      check_outputs($sformatf("stream%0d", c), 1'b1, m_valid, m_pc, 3'(model_q.size()));
      check($sformatf("stream%0d count<=1", c), 32'(count_out <= 3'd1), 32'd1);
      $display("stream%0d: pc_in=0x%0h -> valid=%0d pc_out=0x%0h count=%0d",
               c, pc_in, valid_out, pc_out, count_out);
      if (m_valid) void'(model_q.pop_front());
      if (c < 10) model_q.push_back(pc_in);
    end

    // Empty-queue latency: same cycle with bypass, one cycle later without.
    @(negedge clk);
    drive(0, 0, 1, 32'h300, 1);
    #1;
`ifdef RV32_DECODE_QUEUE_BYPASS_EN
    check_outputs("bypass_c0", 1'b1, 1'b1, 32'h300, 3'd0);
`else
    check_outputs("bypass_c0", 1'b1, 1'b0, 32'h0, 3'd0);
`endif
    $display("bypass_c0: pc_in=0x300 -> valid=%0d pc_out=0x%0h count=%0d", valid_out, pc_out, count_out);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 1);
    #1;
`ifdef RV32_DECODE_QUEUE_BYPASS_EN
    check_outputs("bypass_c1", 1'b1, 1'b0, 32'h0, 3'd0);
`else
    check_outputs("bypass_c1", 1'b1, 1'b1, 32'h300, 3'd1);
`endif
    $display("bypass_c1: -> valid=%0d pc_out=0x%0h count=%0d", valid_out, pc_out, count_out);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0);
    #1;
    check_outputs("bypass_c2", 1'b1, 1'b0, 32'h0, 3'd0);
    $display("bypass_c2: -> valid=%0d pc_out=0x%0h count=%0d", valid_out, pc_out, count_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_decode_queue.md
RV32_DECODE_QUEUE -- requirements
Module: rv32_decode_queue

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are powers of two, 2..64.
REQ-003 Parameter PC_WIDTH, default 32, SHALL set the program-counter width.
REQ-004 Parameter INSTR_WIDTH, default 32, SHALL set the instruction word width.
REQ-005 Port clk  in  1: rising-edge clock.
REQ-006 Port reset  in  1: synchronous active-high reset.
REQ-007 Port flush_in  in  1: discard all queued entries (branch mispredict or trap).
REQ-008 Port valid_in  in  1: fetch presents an entry.
REQ-009 Port ready_out  out  1: queue accepts an entry this cycle.
REQ-010 Port pc_in  in  PC_WIDTH: PC of the fetched instruction.
REQ-011 Port instr_in  in  INSTR_WIDTH: fetched instruction word.
REQ-012 Port branch_predicted_taken_in  in  1: fetch prediction flag.
REQ-013 Port valid_out  out  1: head entry available to decode.
REQ-014 Port ready_in  in  1: decode consumes the head entry this cycle.
REQ-015 Port pc_out  out  PC_WIDTH: head-entry PC.
REQ-016 Port instr_out  out  INSTR_WIDTH: head-entry instruction word.
REQ-017 Port branch_predicted_taken_out  out  1: head-entry prediction flag.
REQ-018 Port count_out  out  clog2(DEPTH+1): current occupancy.

Function
REQ-019 The block SHALL be a circular FIFO with read and write pointers of clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty across wrap-around.
REQ-020 A push SHALL occur when valid_in, ready_out and !flush_in are all high in the same cycle.
REQ-021 A pop SHALL occur when valid_out and ready_in are both high in the same cycle.
REQ-022 ready_out SHALL be high iff count < DEPTH and reset is low; it SHALL depend only on registered state, with no combinational path from ready_in.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-024 valid_out SHALL be high iff count != 0, except as extended by REQ-034.
REQ-025 pc_out, instr_out and branch_predicted_taken_out SHALL show the head entry when valid_out=1, and SHALL be driven to 0 when valid_out=0.
REQ-026 Entries SHALL leave the queue in push order.
REQ-027 Push-to-visible latency SHALL be one cycle: an entry pushed at edge N is at the head, if the queue was empty, from after edge N.
REQ-028 On flush_in=1, count and both pointers SHALL be 0 after the edge; any push in that cycle SHALL be dropped.
REQ-029 A pop handshake in a flush cycle SHALL be treated as taken by decode; the entry is still discarded with the rest of the queue.
REQ-030 count SHALL never exceed DEPTH and never underflow; valid_in while full SHALL be ignored and the input held by fetch.

Reset
REQ-031 While reset=1, ready_out SHALL be 0 and valid_out SHALL be 0.
REQ-032 After the reset edge: count_out=0, pointers 0, valid_out=0, data outputs 0, ready_out=1 once reset is released.
REQ-033 Storage array contents SHALL NOT be reset; they are never visible because of REQ-025.
REQ-033a Reset SHALL take priority over flush, push and pop; reset asserted mid-operation SHALL empty the queue at the next edge.

Configuration
REQ-034 Macro RV32_DECODE_QUEUE_BYPASS_EN defined: when count=0, valid_in=1, flush_in=0 and reset=0, valid_out SHALL be 1 and outputs SHALL mirror the inputs combinationally. If ready_in is also 1, the entry SHALL be consumed without being stored, and count SHALL stay 0.
REQ-035 Macro RV32_DECODE_QUEUE_BYPASS_EN undefined: no combinational path from any input to valid_out or data outputs; REQ-027 latency applies.

Verification
REQ-036 Reset, then push pc 0x100/0x104/0x108/0x10C with ready_in=0 -> count_out 4, ready_out 0; fifth push is held, count stays 4.
REQ-037 Drain with ready_in=1 -> pc_out sequence 0x100, 0x104, 0x108, 0x10C, then valid_out 0 and pc_out 0.
REQ-038 Continuous push and pop for 10 entries across pointer wrap (DEPTH=4) -> order preserved; count never exceeds 1 after the first fill cycle.
REQ-039 Three entries queued, flush_in=1 with valid_in=1 pc 0x200 -> next cycle count_out 0, valid_out 0; 0x200 never appears.
REQ-040 BYPASS_EN build, empty queue, valid_in=1 pc 0x300, ready_in=1 -> pc_out 0x300 in the same cycle, count stays 0. Non-bypass build -> pc_out 0x300 one cycle later.
REQ-041 Reset asserted with two entries queued and a push pending -> next cycle count 0, valid_out 0, ready_out 0 while reset is held.
